// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan decoder: the legal segment
// patterns (bit6=a .. bit0=g, active high), the blank digit code and the
// capture FSM state type.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b0011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1110011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Nibble stored for a blanked digit when blank support is built in.
  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Width of the stability counter; it saturates at its all-ones value.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment pattern to BCD digit lookup.
// Optional feature: `define SEG_SCAN_DECODER_BLANK_EN makes the all-off
// pattern a legal blank digit that decodes to BLANK_CODE.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       legal
);

  // Map the segment pattern to a digit; anything off the table is illegal.
  always_comb begin
    value = 4'd0;
    legal = 1'b0;
    case (pattern)
      SEG_0: begin value = 4'd0; legal = 1'b1; end
      SEG_1: begin value = 4'd1; legal = 1'b1; end
      SEG_2: begin value = 4'd2; legal = 1'b1; end
      SEG_3: begin value = 4'd3; legal = 1'b1; end
      SEG_4: begin value = 4'd4; legal = 1'b1; end
      SEG_5: begin value = 4'd5; legal = 1'b1; end
      SEG_6: begin value = 4'd6; legal = 1'b1; end
      SEG_7: begin value = 4'd7; legal = 1'b1; end
      SEG_8: begin value = 4'd8; legal = 1'b1; end
      SEG_9: begin value = 4'd9; legal = 1'b1; end
`ifdef SEG_SCAN_DECODER_BLANK_EN
      SEG_BLANK: begin value = BLANK_CODE; legal = 1'b1; end
`endif
      default: begin value = 4'd0; legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers digit values from a multiplexed seven-segment display bus.
// The seg/dig_sel lines are sampled once, then a pattern must stay unchanged
// for STABLE_CYCLES samples before it is decoded and written to the digit
// selected by the one-hot dig_sel. A seen mask tracks which digits have been
// captured and pulses frame_done when all of them have.
// Optional feature: `define SEG_SCAN_DECODER_BLANK_EN accepts the all-off
// pattern as a blank digit (see seg_pattern_decode).
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    upd,
  output logic                    err,
  output logic                    frame_done
);

  localparam logic [CNT_W-1:0]      STABLE_C = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_MAX  = '1;
  localparam logic [NUM_DIGITS-1:0] SEL_ONE  = NUM_DIGITS'(1);
  localparam logic [NUM_DIGITS-1:0] SEL_ALL  = '1;

  // Sample stage (p0) and the previous sample (p1) used for the stability compare.
  logic [6:0]              seg_p0_q, seg_p0_d;
  logic [NUM_DIGITS-1:0]   sel_p0_q, sel_p0_d;
  logic [6:0]              seg_p1_q, seg_p1_d;
  logic [NUM_DIGITS-1:0]   sel_p1_q, sel_p1_d;

  // Capture FSM and stability counter.
  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    capture;

  // Captured digit storage and registered pulse outputs.
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [NUM_DIGITS-1:0]   seen_next;
  logic                    upd_q, upd_d;
  logic                    err_q, err_d;
  logic                    frame_q, frame_d;

  // Decoder results for the current sample.
  logic [3:0]              dec_value;
  logic                    dec_legal;
  logic                    sel_onehot;
  logic                    sample_same;

  function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - SEL_ONE)) == '0);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  seg_pattern_decode u_decode (
    .pattern (seg_p0_q),
    .value   (dec_value),
    .legal   (dec_legal)
  );

  // Sample pipeline: register the raw bus, then keep the prior sample for comparison.
  always_comb begin
    seg_p0_d    = seg;
    sel_p0_d    = dig_sel;
    seg_p1_d    = seg_p0_q;
    sel_p1_d    = sel_p0_q;
    sel_onehot  = is_onehot(sel_p0_q);
    sample_same = (seg_p0_q == seg_p1_q) && (sel_p0_q == sel_p1_q);
  end

  // Next-state logic: count identical one-hot samples and flag a capture at the threshold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_onehot) begin
          state_d = TRACK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      TRACK: begin
        if (!sel_onehot) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (sample_same) begin
          cnt_d   = sat_inc(cnt_q);
        end else begin
          cnt_d   = CNT_ONE;
        end
      end
      HOLD: begin
        if (!sel_onehot) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!sample_same) begin
          state_d = TRACK;
          cnt_d   = CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // A threshold of 1 can be met on the very cycle TRACK is entered.
    if ((state_d == TRACK) && (cnt_d >= STABLE_C)) begin
      capture = 1'b1;
      state_d = HOLD;
    end
  end

  // Capture datapath: write the addressed digit, update the seen mask, form pulses.
  always_comb begin
    digits_d  = digits_q;
    valid_d   = valid_q;
    seen_d    = seen_q;
    seen_next = seen_q | sel_p0_q;
    upd_d     = 1'b0;
    err_d     = 1'b0;
    frame_d   = 1'b0;
    if (capture) begin
      upd_d = 1'b1;
      err_d = !dec_legal;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (sel_p0_q[i]) begin
          // An illegal pattern keeps the old nibble but drops its valid flag.
          if (dec_legal) begin
            digits_d[4*i +: 4] = dec_value;
          end
          valid_d[i] = dec_legal;
        end
      end
      if (seen_next == SEL_ALL) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d  = seen_next;
      end
    end
  end

  // State register: synchronous active-low reset clears everything, data included.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_p0_q <= '0;
      sel_p0_q <= '0;
      seg_p1_q <= '0;
      sel_p1_q <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      digits_q <= '0;
      valid_q  <= '0;
      seen_q   <= '0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      seg_p0_q <= seg_p0_d;
      sel_p0_q <= sel_p0_d;
      seg_p1_q <= seg_p1_d;
      sel_p1_q <= sel_p1_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      seen_q   <= seen_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
      frame_q  <= frame_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign upd         = upd_q;
  assign err         = err_q;
  assign frame_done  = frame_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (STABLE_CYCLES=4, NUM_DIGITS=4).
// Expectations for the blank pattern follow SEG_SCAN_DECODER_BLANK_EN.
module tb_seg_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        upd;
  logic        err;
  logic        frame_done;

  seg_scan_decoder #(
    .STABLE_CYCLES (4),
    .NUM_DIGITS    (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .dig_sel     (dig_sel),
    .digits      (digits),
    .digit_valid (digit_valid),
    .upd         (upd),
    .err         (err),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  seg;
    logic [3:0]  sel;
    int          hold;
    int          sep;
    int          upd_step;
    int          upd_cnt;
    int          err_cnt;
    int          frm_cnt;
    logic [15:0] digits;
    logic [3:0]  valid;
  } vec_t;

  vec_t tbl[8];

  int checks;
  int errors;
  int step_no;
  int upd_cnt, err_cnt, frm_cnt;
  int upd_step, err_step, frm_step;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    step_no  = 0;
    upd_cnt  = 0;
    err_cnt  = 0;
    frm_cnt  = 0;
    upd_step = 0;
    err_step = 0;
    frm_step = 0;
  endtask

  // Advance one clock and record the pulse outputs just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    step_no++;
    if (upd === 1'b1) begin
      upd_cnt++;
      if (upd_step == 0) upd_step = step_no;
    end
    if (err === 1'b1) begin
      err_cnt++;
      if (err_step == 0) err_step = step_no;
    end
    if (frame_done === 1'b1) begin
      frm_cnt++;
      if (frm_step == 0) frm_step = step_no;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_digits"}, 32'(digits), 32'h0);
    check({tag, "_valid"}, 32'(digit_valid), 32'h0);
    check({tag, "_upd"}, 32'(upd), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_frame"}, 32'(frame_done), 32'h0);
  endtask

  task automatic run_vec(input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    clear_obs();
    seg     = tbl[idx].seg;
    dig_sel = tbl[idx].sel;
    repeat (tbl[idx].hold) tick();
    if (tbl[idx].sep > 0) begin
      seg     = 7'b0;
      dig_sel = 4'b0;
      repeat (tbl[idx].sep) tick();
    end
    check({tag, "_upd_step"}, 32'(upd_step), 32'(tbl[idx].upd_step));
    check({tag, "_upd_cnt"}, 32'(upd_cnt), 32'(tbl[idx].upd_cnt));
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'(tbl[idx].err_cnt));
    check({tag, "_frm_cnt"}, 32'(frm_cnt), 32'(tbl[idx].frm_cnt));
    check({tag, "_digits"}, 32'(digits), 32'(tbl[idx].digits));
    check({tag, "_valid"}, 32'(digit_valid), 32'(tbl[idx].valid));
    if (tbl[idx].err_cnt > 0) check({tag, "_err_with_upd"}, 32'(err_step), 32'(upd_step));
    if (tbl[idx].frm_cnt > 0) check({tag, "_frm_with_upd"}, 32'(frm_step), 32'(upd_step));
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    seg     = 7'b0;
    dig_sel = 4'b0;

    //            seg         sel      hold sep step upd err frm digits    valid
    tbl[0] = '{7'b1101101, 4'b0010, 6, 3, 5, 1, 0, 0, 16'h0020, 4'b0011};
    tbl[1] = '{7'b1110000, 4'b0100, 5, 3, 5, 1, 0, 0, 16'h0720, 4'b0111};
    tbl[2] = '{7'b1010101, 4'b0100, 5, 3, 5, 1, 1, 0, 16'h0720, 4'b0011};
`ifdef SEG_SCAN_DECODER_BLANK_EN
    tbl[3] = '{7'b0000000, 4'b1000, 5, 3, 5, 1, 0, 1, 16'hF720, 4'b1011};
`else
    tbl[3] = '{7'b0000000, 4'b1000, 5, 3, 5, 1, 1, 1, 16'h0720, 4'b0011};
`endif
    // Back-to-back scan of digits 0..3, no idle gap between digits.
    tbl[4] = '{7'b1111110, 4'b0001, 5, 0, 5, 1, 0, 0, 16'h0000, 4'b0001};
    tbl[5] = '{7'b0110000, 4'b0010, 5, 0, 5, 1, 0, 0, 16'h0010, 4'b0011};
    tbl[6] = '{7'b1101101, 4'b0100, 5, 0, 5, 1, 0, 0, 16'h0210, 4'b0111};
    tbl[7] = '{7'b1111001, 4'b1000, 5, 3, 5, 1, 0, 1, 16'h3210, 4'b1111};

    // Reset state
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // A pattern that changes before it is stable: only the second one is captured.
    clear_obs();
    seg     = 7'b1111001;
    dig_sel = 4'b0001;
    repeat (3) tick();
    seg = 7'b1111110;
    repeat (4) tick();
    seg     = 7'b0;
    dig_sel = 4'b0;
    repeat (4) tick();
    check("bounce_upd_cnt", 32'(upd_cnt), 32'd1);
    check("bounce_upd_step", 32'(upd_step), 32'd8);
    check("bounce_err_cnt", 32'(err_cnt), 32'd0);
    check("bounce_digits", 32'(digits), 32'h0000);
    check("bounce_valid", 32'(digit_valid), 32'h1);

    for (int i = 0; i < 4; i++) run_vec(i);

    // Non-one-hot select never captures.
    clear_obs();
    seg     = 7'b1101101;
    dig_sel = 4'b0011;
    repeat (8) tick();
    check("nonhot_upd_cnt", 32'(upd_cnt), 32'd0);
    seg     = 7'b0;
    dig_sel = 4'b0;
    repeat (3) tick();

    // Reset during the second TRACK cycle aborts the capture.
    clear_obs();
    seg     = 7'b1111111;
    dig_sel = 4'b0001;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_all_zero("midreset");
    rst_n   = 1'b1;
    seg     = 7'b0;
    dig_sel = 4'b0;
    repeat (6) tick();
    check("midreset_upd_cnt", 32'(upd_cnt), 32'd0);

    for (int i = 4; i < 8; i++) run_vec(i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
